// File: rtl/ladybird_fetch_queue_if.sv
// ladybird_bus: single-primary word bus. The primary issues req/addr/wstrb and
// read data returns on data, one word per data_gnt, in request order.
interface ladybird_bus;
   logic        req;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] data;
   logic        gnt;
   logic        data_gnt;

   modport primary   (output req, addr, wstrb, input  data, gnt, data_gnt);
   modport secondary (input  req, addr, wstrb, output data, gnt, data_gnt);
endinterface

// File: rtl/ladybird_fetch_queue.sv
// ladybird_fetch_queue: sequential instruction fetch from a running PC into an
// in-order prefetch FIFO drained by decode; redirect flushes the queue and
// drops responses still in flight.
// Optional build macro LADYBIRD_FETCH_PERF_EN adds saturating perf counters.
module ladybird_fetch_queue #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         anrst,
   input  logic         nrst,
   ladybird_bus.primary bus,
   input  logic         redirect_valid_i,
   input  logic [31:0]  redirect_pc_i,
   output logic         inst_valid_o,
   input  logic         inst_ready_i,
   output logic [31:0]  inst_o,
   output logic [31:0]  inst_pc_o
`ifdef LADYBIRD_FETCH_PERF_EN
   ,
   output logic [31:0]  perf_stall_cycles_o,
   output logic [31:0]  perf_discarded_o,
   output logic [31:0]  perf_fetched_o
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;

   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] outst_q, outst_d;
   logic [CNT_W-1:0] discard_q, discard_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]      hold_inst_q, hold_inst_d;
   logic [31:0]      hold_pc_q, hold_pc_d;
   logic [31:0]      mem_inst_q [DEPTH];
   logic [31:0]      mem_pc_q   [DEPTH];

   logic [OCC_W-1:0] occ_c;
   logic             issue_c;
   logic             accept_c;
   logic             resp_c;
   logic             drop_c;
   logic             keep_c;
   logic             empty_c;
   logic             pop_c;
   logic [31:0]      resp_pc_c;

   // Issue credit and handshake decode; responses with nothing in flight are stale.
   always_comb begin
      occ_c     = OCC_W'(count_q) + OCC_W'(outst_q);
      issue_c   = anrst && nrst && !redirect_valid_i
                  && (outst_q < CNT_W'(MAX_OUTSTANDING))
                  && (occ_c < OCC_W'(DEPTH));
      accept_c  = issue_c && bus.gnt;
      resp_c    = bus.data_gnt && (outst_q != '0);
      drop_c    = resp_c && (discard_q != '0);
      keep_c    = resp_c && !drop_c && !redirect_valid_i;
      empty_c   = (count_q == '0);
      pop_c     = !empty_c && inst_ready_i && !redirect_valid_i;
      // Oldest in-flight read was issued outstanding words behind the current pc.
      resp_pc_c = pc_q - (32'(outst_q) << 2);
   end

   // Next-state for pc, counters, pointers and the empty-hold registers.
   always_comb begin
      pc_d        = pc_q;
      count_d     = count_q;
      outst_d     = outst_q;
      discard_d   = discard_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      hold_inst_d = inst_o;
      hold_pc_d   = inst_pc_o;

      if (accept_c) begin
         pc_d = pc_q + 32'd4;
      end

      if (accept_c && !resp_c) begin
         outst_d = outst_q + CNT_W'(1);
      end else if (!accept_c && resp_c) begin
         outst_d = outst_q - CNT_W'(1);
      end

      if (drop_c) begin
         discard_d = discard_q - CNT_W'(1);
      end

      if (keep_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (keep_c && !pop_c) begin
         count_d = count_q + CNT_W'(1);
      end else if (!keep_c && pop_c) begin
         count_d = count_q - CNT_W'(1);
      end

      // Flush wins over push/pop; everything still in flight becomes discard.
      if (redirect_valid_i) begin
         pc_d      = redirect_pc_i & 32'hFFFF_FFFC;
         count_d   = '0;
         wr_ptr_d  = rd_ptr_q;
         discard_d = outst_d;
      end

      if (!nrst) begin
         pc_d        = RESET_PC;
         count_d     = '0;
         outst_d     = '0;
         discard_d   = '0;
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         hold_inst_d = '0;
         hold_pc_d   = '0;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         pc_q        <= RESET_PC;
         count_q     <= '0;
         outst_q     <= '0;
         discard_q   <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         hold_inst_q <= '0;
         hold_pc_q   <= '0;
      end else begin
         pc_q        <= pc_d;
         count_q     <= count_d;
         outst_q     <= outst_d;
         discard_q   <= discard_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         hold_inst_q <= hold_inst_d;
         hold_pc_q   <= hold_pc_d;
      end
   end

   // FIFO storage; only read while count is non-zero, so no reset needed.
   always_ff @(posedge clk) begin
      if (keep_c) begin
         mem_inst_q[wr_ptr_q] <= bus.data;
         mem_pc_q[wr_ptr_q]   <= resp_pc_c;
      end
   end

   assign inst_valid_o = !empty_c;
   assign inst_o       = empty_c ? hold_inst_q : mem_inst_q[rd_ptr_q];
   assign inst_pc_o    = empty_c ? hold_pc_q   : mem_pc_q[rd_ptr_q];

   assign bus.req   = issue_c;
   assign bus.addr  = {pc_q[31:2], 2'b00};
   assign bus.wstrb = '0;

`ifdef LADYBIRD_FETCH_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_disc_q;
   logic [31:0] perf_fetch_q;

   // Saturating event counters, cleared by either reset.
   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         perf_stall_q <= '0;
         perf_disc_q  <= '0;
         perf_fetch_q <= '0;
      end else if (!nrst) begin
         perf_stall_q <= '0;
         perf_disc_q  <= '0;
         perf_fetch_q <= '0;
      end else begin
         if (empty_c && !redirect_valid_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (drop_c && (perf_disc_q != 32'hFFFF_FFFF)) begin
            perf_disc_q <= perf_disc_q + 32'd1;
         end
         if (keep_c && (perf_fetch_q != 32'hFFFF_FFFF)) begin
            perf_fetch_q <= perf_fetch_q + 32'd1;
         end
      end
   end

   assign perf_stall_cycles_o = perf_stall_q;
   assign perf_discarded_o    = perf_disc_q;
   assign perf_fetched_o      = perf_fetch_q;
`endif

endmodule

// File: doc/ladybird_fetch_queue.md
Name: ladybird_fetch_queue

Overview:
Instruction fetch stage that sits directly upstream of the instruction RAM on a ladybird_bus. It acts as the bus primary and issues sequential word reads from a running PC. Returned words go into a small in-order prefetch FIFO that the decode stage drains with a valid/ready handshake. A redirect input (jump/branch) flushes the queue and discards read responses still in flight.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
MAX_OUTSTANDING, 2, max accepted-but-unanswered bus reads, 1..DEPTH
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock
anrst  input  1  asynchronous active-low reset
nrst  input  1  synchronous active-low reset, same effect as anrst
bus  ladybird_bus.primary  interface  uses req, addr, wstrb, data, gnt, data_gnt
redirect_valid  input  1  flush the queue and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] are ignored
inst_valid  output  1  head FIFO entry is valid
inst_ready  input  1  decode accepts the head entry
inst  output  32  instruction word at the head
inst_pc  output  32  address of inst

Behaviour:
- Reset is asserted by anrst low (asynchronous) or nrst low at a clock edge. On reset:
  - pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - bus.req=0, bus.wstrb=0, inst_valid=0, inst=0, inst_pc=0.
- Reset mid-operation drops all entries. A response arriving after reset release for a pre-reset request is counted against neither counter and is ignored.
- Bus side is read-only:
  - wstrb is always 0; bus.data is not driven ('z).
  - addr = {pc[31:2],2'b00}.
- Issue condition: req=1 when all of the following hold:
  - not in reset
  - redirect_valid=0
  - outstanding < MAX_OUTSTANDING
  - fifo_count + outstanding < DEPTH
- This guarantees FIFO space for every accepted read.
- Request accept is req && gnt. On accept: pc += 4 (wraps modulo 2^32); outstanding++.
- Responses arrive in order, one per data_gnt. On data_gnt: outstanding--.
  - If discard>0: discard--, data dropped.
  - Otherwise push {data, pc_of_request} into the FIFO.
  - Request PCs are kept in an internal DEPTH-entry tag queue, or derived as pc - 4*outstanding at response time.
- Accept and response in the same cycle leave outstanding unchanged.
- Latency with a 1-cycle RAM (gnt=1): req accepted at cycle N, data_gnt at N+1, inst_valid=1 at N+2. Sustained throughput is 1 word/cycle when MAX_OUTSTANDING>=2 and decode is always ready.
- FIFO:
  - inst/inst_pc come from the head entry; inst_valid = (count!=0).
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle are legal at any count, including full.
  - inst/inst_pc hold their last value when empty.
- Redirect (one-cycle pulse or held):
  - FIFO cleared; count=0; inst_valid=0 in the next cycle.
  - pc={redirect_pc[31:2],2'b00}.
  - discard = outstanding after this cycle's accept/response update, so in-flight reads are dropped.
  - req=0 in the redirect cycle; fetch resumes the following cycle.
- Redirect simultaneous with a pop: the pop is ignored (the flush wins). Redirect simultaneous with data_gnt: that word is dropped.
- Back-to-back redirects: each one reloads pc and recomputes discard; the last one wins.
- Decode stalled (inst_ready=0): the FIFO fills to DEPTH and req stays low until a pop frees space.
- The design needs no state machine beyond these counters. Control states are RUN (issuing) and HOLD (credit exhausted), purely combinational from the counters.

Optional Feature:
LADYBIRD_FETCH_PERF_EN
- Defined: adds output ports perf_stall_cycles[31:0], perf_discarded[31:0], perf_fetched[31:0].
  - perf_stall_cycles: cycles with inst_valid=0 && !redirect_valid.
  - perf_discarded: responses dropped through discard.
  - perf_fetched: words pushed into the FIFO.
  - All three are saturating, cleared by either reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release with the bus tied to ladybird_ram (gnt=1, 1-cycle data), inst_ready=1 -> addr 0x0,0x4,0x8,... issued on consecutive cycles; inst_pc=0x0 valid 2 cycles after the first req; then one inst per cycle with inst_pc incrementing by 4.
- inst_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 entries held, req low, outstanding=0; then inst_ready=1 -> inst_pc 0x0..0xC drain in order, with no gap when fetch resumes.
- Redirect to 0x10 while 2 reads are outstanding (to 0x8 and 0xC) -> both responses dropped; next inst_pc=0x10; no entry with inst_pc 0x8 or 0xC ever becomes valid.
- Redirect coincident with data_gnt and with inst_ready=1 -> the returning word is dropped, the head is not popped, and the FIFO is empty next cycle.
- Bus model with gnt held low 3 cycles and 3-cycle response latency -> addr stable while gnt=0; in-order delivery; outstanding never exceeds MAX_OUTSTANDING=2.
- nrst pulsed low mid-stream, then redirect_pc=0x13 -> all state cleared, fetch restarts at RESET_PC after reset; the redirect fetches 0x10 (low bits masked).
